// File: rtl/id_ex_stage_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_register_pkg
// Description : Shared widths, register-file and control-word constants, and
//               the per-edge action selector for the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_register_pkg;

    localparam int c_data_w = 8;
    localparam int c_addr_w = 4;
    localparam int c_ctrl_w = 12;
    localparam int c_cnt_w  = 8;

    // Register 0 is hardwired to zero and can never be a hazard source.
    localparam int c_zero_reg = 0;

    // Bit positions inside the execute/memory/writeback control word.
    localparam int c_ctrl_mem_read  = 0;
    localparam int c_ctrl_mem_write = 1;
    localparam int c_ctrl_reg_write = 2;
    localparam int c_ctrl_mem_to_reg = 3;
    localparam int c_ctrl_alu_src   = 4;
    localparam int c_ctrl_alu_op_lo = 5;
    localparam int c_ctrl_alu_op_hi = 8;
    localparam int c_ctrl_branch    = 9;
    localparam int c_ctrl_jump      = 10;
    localparam int c_ctrl_link      = 11;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_SQUASH = 2'd2,
        ACT_BUBBLE = 2'd3
    } stage_action_e;

    // Priority: flush > execute stall > load-use hazard > normal load.
    function automatic stage_action_e select_action(input logic flush,
                                                    input logic ex_stall,
                                                    input logic hazard);
        if (flush)
            return ACT_SQUASH;
        else if (ex_stall)
            return ACT_HOLD;
        else if (hazard)
            return ACT_BUBBLE;
        else
            return ACT_LOAD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_register_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_register_if
// Description : Decode-side inputs and execute-side outputs of the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_register_if
    import id_ex_stage_register_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int ADDR_W = c_addr_w,
    parameter int CTRL_W = c_ctrl_w,
    parameter int CNT_W  = c_cnt_w
);
    logic              id_valid;
    logic [DATA_W-1:0] id_data_top;
    logic [DATA_W-1:0] id_data_bot;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_mem_read;
    logic [ADDR_W-1:0] id_rd_addr;
    logic [ADDR_W-1:0] id_rs_a;
    logic [ADDR_W-1:0] id_rs_b;
    logic              id_rs_a_used;
    logic              id_rs_b_used;
    logic              ex_stall;
    logic              flush;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_data_top;
    logic [DATA_W-1:0] ex_data_bot;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_mem_read;
    logic [ADDR_W-1:0] ex_rd_addr;
    logic              id_stall;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output id_valid, id_data_top, id_data_bot, id_ctrl, id_mem_read,
               id_rd_addr, id_rs_a, id_rs_b, id_rs_a_used, id_rs_b_used,
               ex_stall, flush,
        input  ex_valid, ex_data_top, ex_data_bot, ex_ctrl, ex_mem_read,
               ex_rd_addr, id_stall, bubble_count
    );

    modport slave (
        input  id_valid, id_data_top, id_data_bot, id_ctrl, id_mem_read,
               id_rd_addr, id_rs_a, id_rs_b, id_rs_a_used, id_rs_b_used,
               ex_stall, flush,
        output ex_valid, ex_data_top, ex_data_bot, ex_ctrl, ex_mem_read,
               ex_rd_addr, id_stall, bubble_count
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_register_load_use_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_hazard_detect
// Description : Flags a decode instruction that reads the destination of a
//               load currently held in the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_hazard_detect
    import id_ex_stage_register_pkg::*;
#(
    parameter int ADDR_W = c_addr_w
) (
    input  wire logic              ex_valid,
    input  wire logic              ex_mem_read,
    input  wire logic [ADDR_W-1:0] ex_rd_addr,
    input  wire logic              id_valid,
    input  wire logic [ADDR_W-1:0] id_rs_a,
    input  wire logic [ADDR_W-1:0] id_rs_b,
    input  wire logic              id_rs_a_used,
    input  wire logic              id_rs_b_used,
    output logic                   hazard
);
    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(c_zero_reg);

    logic w_ex_is_live_load;
    logic w_src_match;

    assign w_ex_is_live_load = ex_valid & ex_mem_read & (ex_rd_addr != c_zero_addr);
    assign w_src_match       = (id_rs_a_used & (id_rs_a == ex_rd_addr))
                             | (id_rs_b_used & (id_rs_b == ex_rd_addr));
    assign hazard            = w_ex_is_live_load & id_valid & w_src_match;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_register.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_register
// Description : ID/EX pipeline register with load-use bubble insertion,
//               stall/flush handling and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_register
    import id_ex_stage_register_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int ADDR_W = c_addr_w,
    parameter int CTRL_W = c_ctrl_w,
    parameter int CNT_W  = c_cnt_w
) (
    input  wire logic             clk,
    input  wire logic             rst,
    id_ex_stage_register_if.slave bus
);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_data_top;
    logic [DATA_W-1:0] r_ex_data_bot;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic              r_ex_mem_read;
    logic [ADDR_W-1:0] r_ex_rd_addr;
    logic [CNT_W-1:0]  r_bubble_count;

    logic              w_hazard;
    stage_action_e     w_action;

    load_use_hazard_detect #(
        .ADDR_W (ADDR_W)
    ) u_hazard (
        .ex_valid     (r_ex_valid),
        .ex_mem_read  (r_ex_mem_read),
        .ex_rd_addr   (r_ex_rd_addr),
        .id_valid     (bus.id_valid),
        .id_rs_a      (bus.id_rs_a),
        .id_rs_b      (bus.id_rs_b),
        .id_rs_a_used (bus.id_rs_a_used),
        .id_rs_b_used (bus.id_rs_b_used),
        .hazard       (w_hazard)
    );

    always_comb begin
        w_action = select_action(bus.flush, bus.ex_stall, w_hazard);
    end

    // A flush releases decode immediately: whatever it holds is being replaced.
    assign bus.id_stall = ~bus.flush & (bus.ex_stall | w_hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_data_top <= '0;
            r_ex_data_bot <= '0;
            r_ex_ctrl     <= '0;
            r_ex_mem_read <= 1'b0;
            r_ex_rd_addr  <= '0;
        end else begin
            case (w_action)
                ACT_SQUASH, ACT_BUBBLE: begin
                    r_ex_valid    <= 1'b0;
                    r_ex_data_top <= '0;
                    r_ex_data_bot <= '0;
                    r_ex_ctrl     <= '0;
                    r_ex_mem_read <= 1'b0;
                    r_ex_rd_addr  <= '0;
                end
                ACT_LOAD: begin
                    // An empty slot must never carry live control downstream.
                    r_ex_valid    <= bus.id_valid;
                    r_ex_data_top <= bus.id_data_top;
                    r_ex_data_bot <= bus.id_data_bot;
                    r_ex_ctrl     <= bus.id_valid ? bus.id_ctrl : '0;
                    r_ex_mem_read <= bus.id_valid & bus.id_mem_read;
                    r_ex_rd_addr  <= bus.id_rd_addr;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_count <= '0;
        end else if ((w_action == ACT_BUBBLE) && (r_bubble_count != c_cnt_max)) begin
            r_bubble_count <= r_bubble_count + c_cnt_one;
        end
    end

    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_data_top  = r_ex_data_top;
    assign bus.ex_data_bot  = r_ex_data_bot;
    assign bus.ex_ctrl      = r_ex_ctrl;
    assign bus.ex_mem_read  = r_ex_mem_read;
    assign bus.ex_rd_addr   = r_ex_rd_addr;
    assign bus.bubble_count = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_register
// Description : Self-checking bench for id_ex_stage_register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_register;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 12;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_register_if #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) bus ();

    id_ex_stage_register #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the execute stage should hold right now.
    bit          m_known = 1'b0;
    bit          m_valid;
    int unsigned m_top, m_bot, m_ctrl, m_rd;
    bit          m_mr;
    int unsigned m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        bit src_hit;
        src_hit = (bus.id_rs_a_used && (int'(bus.id_rs_a) == m_rd))
               || (bus.id_rs_b_used && (int'(bus.id_rs_b) == m_rd));
        return m_valid && m_mr && (m_rd != 0) && bus.id_valid && src_hit;
    endfunction

    function automatic bit model_stall();
        return !bus.flush && (bus.ex_stall || model_hazard());
    endfunction

    task automatic model_clear();
        m_valid = 0; m_top = 0; m_bot = 0; m_ctrl = 0; m_mr = 0; m_rd = 0;
    endtask

    // Applied right after each rising edge with the inputs that edge saw.
    task automatic model_update(input bit hz);
        if (rst) begin
            model_clear();
            m_cnt   = 0;
            m_known = 1'b1;
        end else if (bus.flush) begin
            model_clear();
        end else if (bus.ex_stall) begin
            // contents hold
        end else if (hz) begin
            model_clear();
            if (m_cnt < 255) m_cnt = m_cnt + 1;
        end else begin
            m_valid = bus.id_valid;
            m_top   = bus.id_data_top;
            m_bot   = bus.id_data_bot;
            m_ctrl  = bus.id_valid ? int'(bus.id_ctrl) : 0;
            m_mr    = bus.id_valid && bus.id_mem_read;
            m_rd    = bus.id_rd_addr;
        end
    endtask

    task automatic compare_all();
        if (!m_known) return;
        chk("ex_valid",     32'(bus.ex_valid),     32'(m_valid));
        chk("ex_data_top",  32'(bus.ex_data_top),  m_top);
        chk("ex_data_bot",  32'(bus.ex_data_bot),  m_bot);
        chk("ex_ctrl",      32'(bus.ex_ctrl),      m_ctrl);
        chk("ex_mem_read",  32'(bus.ex_mem_read),  32'(m_mr));
        chk("ex_rd_addr",   32'(bus.ex_rd_addr),   m_rd);
        chk("id_stall",     32'(bus.id_stall),     32'(model_stall()));
        chk("bubble_count", 32'(bus.bubble_count), m_cnt);
    endtask

    // Inputs are set just after a falling edge; this checks, clocks, and
    // returns just after the next falling edge.
    task automatic cycle();
        bit hz;
        #1;
        compare_all();
        hz = model_hazard();
        @(posedge clk);
        model_update(hz);
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input logic [7:0] top, input logic [7:0] bot,
                          input logic [11:0] ctrl, input bit mr, input logic [3:0] rd,
                          input logic [3:0] a, input logic [3:0] b, input bit au, input bit bu);
        bus.id_valid     = v;
        bus.id_data_top  = top;
        bus.id_data_bot  = bot;
        bus.id_ctrl      = ctrl;
        bus.id_mem_read  = mr;
        bus.id_rd_addr   = rd;
        bus.id_rs_a      = a;
        bus.id_rs_b      = b;
        bus.id_rs_a_used = au;
        bus.id_rs_b_used = bu;
    endtask

    task automatic randomize_id();
        set_id($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 12'($urandom),
               $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.ex_stall = 1'b0;
        randomize_id();
        @(negedge clk);

        // Reset dominates garbage inputs for two cycles.
        cycle();
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_count",    32'(bus.bubble_count), 32'd0);
        bus.flush = 1'b1; bus.ex_stall = 1'b1;
        cycle();
        chk("rst_ex_ctrl",  32'(bus.ex_ctrl), 32'd0);
        chk("rst_ex_top",   32'(bus.ex_data_top), 32'd0);

        // First instruction streams through with one-cycle latency.
        rst = 1'b0; bus.flush = 1'b0; bus.ex_stall = 1'b0;
        set_id(1, 8'h3C, 8'hA5, 12'h123, 0, 4'd3, 4'd0, 4'd0, 0, 0);
        cycle();
        chk("stream_top",   32'(bus.ex_data_top), 32'h3C);
        chk("stream_bot",   32'(bus.ex_data_bot), 32'hA5);
        chk("stream_rd",    32'(bus.ex_rd_addr),  32'd3);
        chk("stream_valid", 32'(bus.ex_valid),    32'd1);

        // Load-use hazard: load r5 in EX, decode reads r5.
        set_id(1, 8'h11, 8'h22, 12'h0F1, 1, 4'd5, 4'd0, 4'd0, 0, 0);
        cycle();
        set_id(1, 8'h33, 8'h44, 12'h00E, 0, 4'd6, 4'd5, 4'd2, 1, 1);
        #1 chk("hz_stall_now", 32'(bus.id_stall), 32'd1);
        cycle();
        chk("hz_bubble_valid", 32'(bus.ex_valid),     32'd0);
        chk("hz_count_one",    32'(bus.bubble_count), 32'd1);
        #1 chk("hz_released",  32'(bus.id_stall),     32'd0);
        cycle();
        chk("hz_loaded_rd",    32'(bus.ex_rd_addr),   32'd6);
        chk("hz_loaded_valid", 32'(bus.ex_valid),     32'd1);

        // Register 0 and unused sources never hazard.
        set_id(1, 8'h01, 8'h02, 12'h001, 1, 4'd0, 4'd0, 4'd0, 0, 0);
        cycle();
        set_id(1, 8'h03, 8'h04, 12'h004, 0, 4'd1, 4'd0, 4'd0, 1, 1);
        #1 chk("r0_no_stall", 32'(bus.id_stall), 32'd0);
        cycle();
        set_id(1, 8'h05, 8'h06, 12'h001, 1, 4'd5, 4'd0, 4'd0, 0, 0);
        cycle();
        set_id(1, 8'h07, 8'h08, 12'h004, 0, 4'd2, 4'd1, 4'd5, 1, 0);
        #1 chk("unused_no_stall", 32'(bus.id_stall), 32'd0);
        cycle();
        chk("unused_count", 32'(bus.bubble_count), 32'd1);

        // Downstream stall holds for three cycles, then flush wins over stall.
        bus.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            #1 chk("stall_id_stall", 32'(bus.id_stall), 32'd1);
            cycle();
            chk("stall_hold_top", 32'(bus.ex_data_top), 32'h07);
        end
        bus.flush = 1'b1;
        #1 chk("flush_id_stall", 32'(bus.id_stall), 32'd0);
        cycle();
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_ctrl",  32'(bus.ex_ctrl),  32'd0);
        bus.flush = 1'b0; bus.ex_stall = 1'b0;

        // Force 260 bubbles to saturate the counter.
        for (int i = 0; i < 260; i++) begin
            set_id(1, 8'($urandom), 8'($urandom), 12'h001, 1, 4'd7, 4'd0, 4'd0, 0, 0);
            cycle();
            set_id(1, 8'($urandom), 8'($urandom), 12'h000, 0, 4'd8, 4'd7, 4'd0, 1, 0);
            cycle();
        end
        chk("sat_255", 32'(bus.bubble_count), 32'd255);
        bus.flush = 1'b1;
        cycle();
        chk("sat_after_flush", 32'(bus.bubble_count), 32'd255);
        bus.flush = 1'b0;
        rst = 1'b1;
        cycle();
        chk("sat_rst_clear", 32'(bus.bubble_count), 32'd0);
        rst = 1'b0;

        // Reset arriving in a hazard cycle: no bubble counted.
        set_id(1, 8'h55, 8'h66, 12'h001, 1, 4'd9, 4'd0, 4'd0, 0, 0);
        cycle();
        set_id(1, 8'h77, 8'h88, 12'h002, 0, 4'd1, 4'd0, 4'd9, 0, 1);
        #1 chk("midrst_hz", 32'(bus.id_stall), 32'd1);
        rst = 1'b1;
        cycle();
        chk("midrst_count", 32'(bus.bubble_count), 32'd0);
        chk("midrst_valid", 32'(bus.ex_valid),     32'd0);
        chk("midrst_rd",    32'(bus.ex_rd_addr),   32'd0);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            bus.flush    = ($urandom_range(0, 15) == 0);
            bus.ex_stall = ($urandom_range(0, 7) == 0);
            randomize_id();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage_register.md
Name: id_ex_stage_register

Overview:
- Pipeline register between the decode stage and the execute stage.
- Captures the decode data-mux outputs (top/bottom operand), the control word and the destination register address.
- Detects load-use hazards against the instruction currently held for execute. On a hazard it stalls decode and inserts a one-cycle bubble.
- Honours downstream stall and branch flush, and keeps a saturating bubble-count performance counter.

Parameters:
DATA_W, 8, operand width (matches the decode data mux outputs)
ADDR_W, 4, register-file address width
CTRL_W, 12, execute/memory/writeback control word width
CNT_W, 8, bubble counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  decode holds a valid instruction
id_data_top  in  DATA_W  top operand from decode data mux
id_data_bot  in  DATA_W  bottom operand (immediate or register) from decode data mux
id_ctrl  in  CTRL_W  decoded control word
id_mem_read  in  1  instruction is a load
id_rd_addr  in  ADDR_W  destination register
id_rs_a / id_rs_b  in  ADDR_W each  source registers
id_rs_a_used / id_rs_b_used  in  1 each  source actually read
ex_stall  in  1  execute stage cannot accept; hold contents
flush  in  1  taken branch/jump; squash decode→execute transfer
ex_valid  out  1  execute-stage instruction valid
ex_data_top / ex_data_bot  out  DATA_W  registered operands
ex_ctrl  out  CTRL_W  registered control word
ex_mem_read  out  1  registered load flag
ex_rd_addr  out  ADDR_W  registered destination
id_stall  out  1  combinational; holds IF/ID and PC
bubble_count  out  CNT_W  hazard bubbles inserted, saturating

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: all registered outputs are 0 and bubble_count is 0 on the first edge with rst=1. Reset overrides every other input.
- hazard (combinational) = ex_valid & ex_mem_read & (ex_rd_addr != 0) & id_valid & ((id_rs_a_used & id_rs_a==ex_rd_addr) | (id_rs_b_used & id_rs_b==ex_rd_addr)). Register 0 is hardwired and never hazards.
- id_stall = ~flush & (ex_stall | hazard). This is combinational with no latency.
- Per-edge priority, highest first: rst > flush > ex_stall > hazard > load.
  - flush: ex_valid, ex_mem_read and ex_ctrl go to 0; data and rd_addr go to 0. Applies even if ex_stall=1, because the squashed contents are wrong-path.
  - ex_stall (no flush): all ex_* outputs hold.
  - hazard (no flush, no stall): insert a bubble, i.e. the same clearing as flush. bubble_count increments unless it is already all-ones.
  - load: ex_* capture id_* and ex_valid <= id_valid. When id_valid=0, ex_ctrl and ex_mem_read are forced to 0 so an invalid slot never carries live control.
- Latency: 1 cycle from id_* to ex_*.
- A hazard always resolves after exactly one bubble, because the bubble clears ex_valid. The same decode instruction then loads on the following edge.
- ex_stall and hazard together: hold takes effect, no bubble, no count. The hazard re-evaluates next cycle.
- Counter: saturates at 2^CNT_W-1. Cleared only by rst; flush does not clear it.

Decomposition:
- Shared package holds DATA_W, ADDR_W, CTRL_W defaults, the ZERO_REG constant (0) and control-word bit-index constants (MEM_READ, REG_WRITE, …).
- One sub-module, load_use_hazard_detect: purely combinational; produces hazard from the ex_* and id_* addresses. Reused by a future forwarding unit.
- Register bank and counter live in the top module.

Test Plan:
- Reset then stream: rst=1 for 2 cycles, then id_valid=1, data_top=0x3C, data_bot=0xA5, rd=3. Required: all outputs 0 during reset; next edge ex_data_top=0x3C, ex_data_bot=0xA5, ex_rd_addr=3, ex_valid=1.
- Load-use hazard: EX holds load rd=5; ID has rs_a=5 with rs_a_used=1. Required: id_stall=1 same cycle; next edge ex_valid=0 and bubble_count=1; following edge ID instruction loads and id_stall=0.
- Register 0 and unused sources: EX load with rd=0, ID rs_a=0; also EX load rd=5 with ID rs_b=5 but rs_b_used=0. Required: no stall, no bubble, count unchanged.
- Stall plus flush: ex_stall=1 for 3 cycles; outputs hold and id_stall=1. Then flush=1 together with ex_stall=1. Required: ex_valid=0, ex_ctrl=0, id_stall=0 on that edge.
- Counter saturation: force 260 hazard bubbles. Required: bubble_count=255 and stays there; a subsequent flush leaves it at 255; rst clears it to 0.
- Mid-operation reset: assert rst during a hazard cycle. Required: next edge all outputs 0 and bubble_count=0; the hazard bubble is not counted.
